// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_e;

    localparam int unsigned SPI_DATA_W = 8;

    // Wide enough to truncate to any word width
    localparam logic [63:0] SPI_FILL_WORD = '1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulse outputs.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-3 responder clocked from sys_clk.
// Define SPI_SLAVE_ERR_EN for sticky overrun/underrun flags.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              spi_clk_i,
    input  logic              spi_cs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ack_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o
`ifdef SPI_SLAVE_ERR_EN
    ,
    input  logic              rx_ack_i,
    input  logic              err_clr_i,
    output logic              rx_overrun_o,
    output logic              tx_underrun_o
`endif
);

    localparam logic [0:0] ST_IDLE   = 1'(IDLE);
    localparam logic [0:0] ST_ACTIVE = 1'(ACTIVE);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] FILL = DATA_W'(SPI_FILL_WORD);

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    spi_sync_edge #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b1)
    ) u_sclk_sync (
        .clk_i (sys_clk),
        .rst_ni(sys_rst_n),
        .d_i   (spi_clk_i),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    spi_sync_edge #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b1)
    ) u_cs_sync (
        .clk_i (sys_clk),
        .rst_ni(sys_rst_n),
        .d_i   (spi_cs_i),
        .rise_o(cs_rise),
        .fall_o(cs_fall)
    );

    // Extra stage matches the edge detector's compare flop
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mosi_sync_q <= '0;
            mosi_q      <= 1'b0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

    logic [0:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DATA_W-1:0] tx_sh_q,   tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q,   rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_vld_q,  rx_vld_d;
    logic              tx_ack_q,  tx_ack_d;
    logic              miso_q,    miso_d;

    logic in_active;
    logic cs_exit;
    logic run;
    logic fall_load;
    logic rise_last;

    // CS falling is taken first so a coincident SCLK edge still counts
    assign in_active = (state_q == ST_ACTIVE);
    assign cs_exit   = in_active & cs_rise;
    assign run       = ~cs_exit & (in_active | cs_fall);
    assign fall_load = run & sclk_fall & (cnt_q == '0);
    assign rise_last = run & sclk_rise & (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        rx_vld_d  = 1'b0;
        tx_ack_d  = 1'b0;
        miso_d    = miso_q;

        if (cs_exit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
        end else if (run) begin
            state_d = ST_ACTIVE;
            if (sclk_fall) begin
                if (fall_load) begin
                    tx_sh_d  = tx_valid_i ? tx_data_i : FILL;
                    tx_ack_d = tx_valid_i;
                end else begin
                    tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                end
                miso_d = tx_sh_d[DATA_W-1];
            end
            if (sclk_rise) begin
                rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_q};
                if (rise_last) begin
                    cnt_d     = '0;
                    rx_data_d = rx_sh_d;
                    rx_vld_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            rx_vld_q  <= 1'b0;
            tx_ack_q  <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            rx_vld_q  <= rx_vld_d;
            tx_ack_q  <= tx_ack_d;
            miso_q    <= miso_d;
        end
    end

    assign spi_miso_o = miso_q;
    assign tx_ack_o   = tx_ack_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_vld_q;
    assign busy_o     = in_active;

`ifdef SPI_SLAVE_ERR_EN
    logic pend_q,  pend_d;
    logic ovr_q,   ovr_d;
    logic undr_q,  undr_d;

    // A word is pending from its completion until rx_ack_i
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        undr_d = undr_q;
        if (rise_last) begin
            pend_d = 1'b1;
            if (pend_q && !rx_ack_i) begin
                ovr_d = 1'b1;
            end
        end else if (rx_ack_i) begin
            pend_d = 1'b0;
        end
        if (fall_load && !tx_valid_i) begin
            undr_d = 1'b1;
        end
        if (err_clr_i) begin
            ovr_d  = 1'b0;
            undr_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
            undr_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            undr_q <= undr_d;
        end
    end

    assign rx_overrun_o  = ovr_q;
    assign tx_underrun_o = undr_q;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core acting as a mode-3 SPI master.
// Define SPI_SLAVE_ERR_EN to also exercise the error flags.
module tb_spi_slave_core;

    localparam int SS   = 2;
    localparam int HALF = 8;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       spi_clk = 1'b1;
    logic       spi_cs = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso_o;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ack_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       busy_o;
`ifdef SPI_SLAVE_ERR_EN
    logic       rx_ack = 1'b1;
    logic       err_clr = 1'b0;
    logic       rx_overrun_o;
    logic       tx_underrun_o;
`endif

    always #5 sys_clk = ~sys_clk;

    spi_slave_core #(
        .DATA_W     (8),
        .SYNC_STAGES(SS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .spi_clk_i (spi_clk),
        .spi_cs_i  (spi_cs),
        .spi_mosi_i(spi_mosi),
        .spi_miso_o(spi_miso_o),
        .tx_data_i (tx_data),
        .tx_valid_i(tx_valid),
        .tx_ack_o  (tx_ack_o),
        .rx_data_o (rx_data_o),
        .rx_valid_o(rx_valid_o),
        .busy_o    (busy_o)
`ifdef SPI_SLAVE_ERR_EN
        ,
        .rx_ack_i     (rx_ack),
        .err_clr_i    (err_clr),
        .rx_overrun_o (rx_overrun_o),
        .tx_underrun_o(tx_underrun_o)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monotonic event counters; the stimulus takes snapshots
    int         rx_cnt = 0;
    int         ack_cnt = 0;
    int         idle_miso = 0;
    logic [7:0] rx_words[$];

    always @(negedge sys_clk) begin
        if (rx_valid_o) begin
            rx_cnt++;
            rx_words.push_back(rx_data_o);
        end
        if (tx_ack_o) ack_cnt++;
        if (!busy_o && spi_miso_o) idle_miso++;
    end

    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_clk  = 1'b0;
            spi_mosi = tx[7-i];
            repeat (HALF) @(negedge sys_clk);
            rx = {rx[6:0], spi_miso_o};
            spi_clk = 1'b1;
            repeat (HALF) @(negedge sys_clk);
        end
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        repeat (HALF) @(negedge sys_clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge sys_clk);
        spi_cs = 1'b1;
        repeat (HALF) @(negedge sys_clk);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_miso"},  32'(spi_miso_o), 0);
        check({tag, "_ack"},   32'(tx_ack_o),   0);
        check({tag, "_rxd"},   32'(rx_data_o),  0);
        check({tag, "_rxv"},   32'(rx_valid_o), 0);
        check({tag, "_busy"},  32'(busy_o),     0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] m;
        logic [7:0] m2;
        logic       seen;
        int         rb;
        int         ab;

        repeat (3) @(negedge sys_clk);
        check_reset_outs("rst_in");
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        check_reset_outs("rst_out");

        // Single word with valid TX data
        rb = rx_cnt;
        ab = ack_cnt;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        cs_low();
        check("t1_busy", 32'(busy_o), 1);
        xfer(8'hA5, 8, m);
        tx_valid = 1'b0;
        cs_high();
        check("t1_rxn",  32'(rx_cnt - rb),  1);
        check("t1_rxd",  32'(rx_data_o),    'hA5);
        check("t1_miso", 32'(m),            'h3C);
        check("t1_ackn", 32'(ack_cnt - ab), 1);

        // Back-to-back fill words, no RX acknowledge
        rb = rx_cnt;
        ab = ack_cnt;
`ifdef SPI_SLAVE_ERR_EN
        rx_ack = 1'b0;
`endif
        cs_low();
        xfer(8'h01, 8, m);
        xfer(8'h80, 8, m2);
        cs_high();
        check("t2_rxn",   32'(rx_cnt - rb),  2);
        check("t2_w0",    32'(rx_words[rb]),   'h01);
        check("t2_w1",    32'(rx_words[rb+1]), 'h80);
        check("t2_miso0", 32'(m),  'hFF);
        check("t2_miso1", 32'(m2), 'hFF);
        check("t2_ackn",  32'(ack_cnt - ab), 0);
`ifdef SPI_SLAVE_ERR_EN
        check("t2_undr", 32'(tx_underrun_o), 1);
        check("t2_ovr",  32'(rx_overrun_o),  1);
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        rx_ack  = 1'b1;
        @(negedge sys_clk);
        check("t2_ovr_clr",  32'(rx_overrun_o),  0);
        check("t2_undr_clr", 32'(tx_underrun_o), 0);
`endif

        // Abort after five bits, then a clean word
        rb = rx_cnt;
        cs_low();
        xfer(8'hF0, 5, m);
        check("t3_part_miso", 32'(m), 'h1F);
        spi_cs = 1'b0;
        spi_cs = 1'b1;
        repeat (SS + 2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("t3_miso0", 32'(spi_miso_o), 0);
        check("t3_busy0", 32'(busy_o),     0);
        repeat (HALF) @(negedge sys_clk);
        check("t3_norx", 32'(rx_cnt - rb), 0);
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        cs_low();
        xfer(8'h5A, 8, m);
        tx_valid = 1'b0;
        cs_high();
        check("t3_rxn",  32'(rx_cnt - rb), 1);
        check("t3_rxd",  32'(rx_data_o),   'h5A);
        check("t3_miso", 32'(m),           'h96);

        // Reset mid-transfer
        cs_low();
        xfer(8'hC3, 3, m);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check_reset_outs("t4_rst");
        spi_cs = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        rb = rx_cnt;
        cs_low();
        xfer(8'hC3, 8, m);
        cs_high();
        check("t4_rxn", 32'(rx_cnt - rb), 1);
        check("t4_rxd", 32'(rx_data_o),   'hC3);

        // SCLK activity with CS high
        rb   = rx_cnt;
        ab   = ack_cnt;
        seen = 1'b0;
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            spi_clk = 1'b0;
            repeat (HALF) @(negedge sys_clk);
            seen |= busy_o | spi_miso_o;
            spi_clk = 1'b1;
            repeat (HALF) @(negedge sys_clk);
            seen |= busy_o | spi_miso_o;
        end
        tx_valid = 1'b0;
        check("t5_quiet", 32'(seen),          0);
        check("t5_rxn",   32'(rx_cnt - rb),   0);
        check("t5_ackn",  32'(ack_cnt - ab),  0);

        check("idle_miso", 32'(idle_miso), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Synthesizable SPI responder (mode 3: SCLK idles high; MOSI sampled on rising edge; MISO launched on falling edge) clocked entirely from `sys_clk`. It is the RTL counterpart of the DPI SPI master model and is driven by it in simulation. Serial bytes are presented to on-chip logic through a byte-wide receive strobe and a transmit valid/ack handshake.

## Interface
- `DATA_W`, 8: bits per word; MSB first.
- `SYNC_STAGES`, 2: synchronizer depth on `spi_clk_i`, `spi_cs_i` and `spi_mosi_i`; minimum 2.
- `sys_clk` in 1: sole clock.
- `sys_rst_n` in 1: asynchronous assert, active-low reset.
- `spi_clk_i` in 1: SCLK from master, asynchronous.
- `spi_cs_i` in 1: chip select, active-low, asynchronous.
- `spi_mosi_i` in 1: serial data in.
- `spi_miso_o` out 1: serial data out.
- `tx_data_i` in DATA_W: next word to send.
- `tx_valid_i` in 1: `tx_data_i` is valid.
- `tx_ack_o` out 1: one-cycle pulse; `tx_data_i` consumed this cycle.
- `rx_data_o` out DATA_W: last complete received word; held until the next word completes.
- `rx_valid_o` out 1: one-cycle pulse; `rx_data_o` updated this cycle.
- `busy_o` out 1: high while CS is asserted (synchronized).

## Operation
- Reset values: `spi_miso_o`=0, `tx_ack_o`=0, `rx_data_o`=0, `rx_valid_o`=0, `busy_o`=0, state IDLE, bit counter 0, synchronizer flops at idle levels (SCLK=1, CS=1, MOSI=0).
- FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on synchronized CS falling edge.
  - ACTIVE -> IDLE on synchronized CS rising edge, from any bit position.
- Word load: on the first synchronized SCLK falling edge of each word (bit counter 0):
  - If `tx_valid_i`=1: load `tx_data_i` into the shift register and pulse `tx_ack_o`.
  - Otherwise: load all-ones (fill word) and do not pulse `tx_ack_o`.
  - `spi_miso_o` drives the shift-register MSB in the same cycle.
- Falling edges with bit counter ≠ 0 shift the TX register left by one and drive the new MSB.
- Rising SCLK edge: shift the synchronized MOSI into the RX register LSB and increment the bit counter.
- On the DATA_W-th rising edge:
  - Copy the RX register (including the bit just sampled) to `rx_data_o`.
  - Pulse `rx_valid_o` and wrap the bit counter to 0.
  - Back-to-back words within one CS assertion are supported without gaps.
- CS deasserts mid-word: discard the partial word (no `rx_valid_o`), clear the counter, and return `spi_miso_o` to 0 the next cycle. A `tx_ack_o` already issued stays issued; that word is lost.
- SCLK edges while CS is high are ignored. `spi_miso_o`=0 whenever the FSM is in IDLE.
- CS falling and an SCLK edge detected in the same cycle: CS is processed first, then the SCLK edge is acted on in ACTIVE.
- `sys_rst_n` asserted mid-transfer: immediate return to reset values; the next transfer requires a fresh CS falling edge.

## Timing
- Edge detect latency: an edge is acted on SYNC_STAGES+1 `sys_clk` cycles after the first `sys_clk` edge that samples the new pin level.
- `rx_valid_o` rises in that action cycle for the final rising SCLK edge. `spi_miso_o` updates in that action cycle for a falling edge.
- Frequency requirement: `sys_clk` ≥ 2·(SYNC_STAGES+2)× SCLK (8× at defaults), so MISO is stable before the master's next rising edge.
- `tx_data_i` must be valid by the cycle the first falling edge of a word is acted on. The data is sampled only in that cycle.

## Configuration
- `SPI_SLAVE_ERR_EN` defined adds two outputs:
  - `rx_overrun_o`: sticky; set when `rx_valid_o` pulses while the previous word is unacknowledged. Acknowledgement is `rx_ack_i`, a 1-bit input also added under the macro.
  - `tx_underrun_o`: sticky; set when the fill word is loaded.
  - Both flags reset to 0 and clear only via `err_clr_i`, an input also added under the macro.
- Without the macro, these ports and their logic are absent and behaviour is otherwise identical.

## Structure
- Package `spi_pkg`: state enum `spi_slv_state_e` {IDLE, ACTIVE}, constant `SPI_FILL_WORD` (all-ones), default `SPI_DATA_W`=8.
- Sub-module `spi_sync_edge`: SYNC_STAGES-flop synchronizer with registered rise/fall pulse outputs and a parameterized reset level. It is instantiated for SCLK and for CS. MOSI uses a plain synchronizer of equal depth so its alignment with SCLK is preserved.

## Test plan
- Master sends 0xA5 with `tx_data_i`=0x3C and `tx_valid_i`=1 -> `rx_data_o`=0xA5 with a single `rx_valid_o` pulse; MISO bits 0,0,1,1,1,1,0,0; one `tx_ack_o` pulse.
- Two back-to-back words 0x01, 0x80 under one CS with `tx_valid_i`=0 -> two `rx_valid_o` pulses (0x01, then 0x80); MISO all ones; no `tx_ack_o`; `tx_underrun_o`=1 when `SPI_SLAVE_ERR_EN` is defined.
- CS deasserted after 5 SCLK cycles -> no `rx_valid_o`; `spi_miso_o`=0 and `busy_o`=0 within SYNC_STAGES+2 cycles; the next full transfer of 0x5A is received correctly.
- `sys_rst_n` pulsed low after 3 bits -> all outputs at reset values. A new CS/0xC3 transfer yields `rx_data_o`=0xC3.
- SCLK toggled 8× with CS high -> no `rx_valid_o`, `tx_ack_o` or `busy_o`; `spi_miso_o` stays 0.
- With `SPI_SLAVE_ERR_EN`, receive 2 words without `rx_ack_i` -> `rx_overrun_o`=1; `err_clr_i` pulse -> `rx_overrun_o`=0.
